// File: rtl/mult32x32_req_ctrl.sv
// Request front-end for mult32x32_fast: operand FIFO, issue/wait FSM and result register.
// Optional MULT_REQ_STATS_EN adds saturating op/busy counters with a synchronous clear.
module mult32x32_req_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MULT_REQ_STATS_EN
    input  logic        stats_clr,
    output logic [31:0] op_count,
    output logic [31:0] busy_cycles,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mult_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_busy,
    input  logic [63:0] mult_product,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_product
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fifo_a [DEPTH];
    logic [31:0]        fifo_b [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic               full;
    logic               empty;
    logic               can_accept;
    logic               push;
    logic               pop;
    logic               capture;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign can_accept = !res_valid || res_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign in_ready   = !full || pop;
    assign push       = in_valid && in_ready;
    assign mult_a     = a_reg;
    assign mult_b     = b_reg;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        capture    = 1'b0;
        mult_start = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && can_accept && !mult_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Busy rises combinationally with start, so it is not sampled here.
                mult_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (!mult_busy) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (pop) begin
            a_reg <= fifo_a[rd_ptr];
            b_reg <= fifo_b[rd_ptr];
        end
    end

    // Capture wins over drain: a drain and capture in one cycle keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_product <= '0;
        end else if (capture) begin
            res_valid   <= 1'b1;
            res_product <= mult_product;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

`ifdef MULT_REQ_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count    <= '0;
            busy_cycles <= '0;
        end else if (stats_clr) begin
            op_count    <= '0;
            busy_cycles <= '0;
        end else begin
            if (capture) begin
                op_count <= sat_inc(op_count);
            end
            if (state == ISSUE || state == WAIT) begin
                busy_cycles <= sat_inc(busy_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult32x32_req_ctrl.sv
// Scoreboard bench for mult32x32_req_ctrl with a behavioural mult32x32_fast model
// (fast path when either operand's upper half is zero, otherwise busy for 4 cycles).
module tb_mult32x32_req_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_product;
`ifdef MULT_REQ_STATS_EN
    logic        stats_clr;
    logic [31:0] op_count;
    logic [31:0] busy_cycles;
`endif

    mult32x32_req_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef MULT_REQ_STATS_EN
        .stats_clr    (stats_clr),
        .op_count     (op_count),
        .busy_cycles  (busy_cycles),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_product  (res_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: product sampled from the live operands on every busy cycle.
    logic [1:0]  m_cnt;
    logic [63:0] m_prod;
    assign mult_busy    = mult_start | (m_cnt != 2'd0);
    assign mult_product = m_prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 2'd0;
            m_prod <= 64'd0;
        end else begin
            if (mult_start)
                m_cnt <= (mult_a[31:16] == 16'd0 || mult_b[31:16] == 16'd0) ? 2'd0 : 2'd3;
            else if (m_cnt != 2'd0)
                m_cnt <= m_cnt - 2'd1;
            if (mult_busy)
                m_prod <= 64'(mult_a) * 64'(mult_b);
        end
    end

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor state
    int          starts   = 0;
    int          rv_cycles = 0;
    int          gap      = 0;
    int          max_gap  = 0;
    bit          seen_rv  = 0;
    bit          act      = 0;
    bit          stab_err = 0;
    int          meas     = 0;
    logic [31:0] lat_a;
    logic [31:0] lat_b;

    always @(negedge clk) begin
        #3;
        if (reset) begin
            act = 0;
        end else begin
            if (mult_start) begin
                starts++;
                meas++;
                act      = 1;
                stab_err = 0;
                lat_a    = mult_a;
                lat_b    = mult_b;
            end else if (act) begin
                meas++;
                if (mult_a !== lat_a || mult_b !== lat_b)
                    stab_err = 1;
                if (!mult_busy) begin
                    act = 0;
                    check("operand_hold", 64'(stab_err), 64'd0);
                end
            end
            if (res_valid) begin
                rv_cycles++;
                if (seen_rv && gap > max_gap)
                    max_gap = gap;
                seen_rv = 1;
                gap     = 0;
            end else begin
                gap++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%h, expected no result", res_product);
                end else begin
                    check("result", res_product, exp_q.pop_front());
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after the pair is accepted.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bit done = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(exp);
                @(negedge clk);
                done = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0, expected 1 for a=0x%h", a);
        end
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #4;
            if (exp_q.size() == 0 && !res_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int rv0;
        bit seen_start;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
`ifdef MULT_REQ_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_mult_start", 64'(mult_start), 64'd0);
        check("reset_res_product", res_product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_mult_a", {mult_a, mult_b}, 64'd0);
        @(negedge clk);

        // Fast path
        res_ready = 1'b1;
        s0  = starts;
        rv0 = rv_cycles;
        push(32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
        wait_drain(50);
        repeat (3) @(negedge clk);
        check("fast_start_pulses", 64'(starts - s0), 64'd1);
        check("fast_res_valid_cycles", 64'(rv_cycles - rv0), 64'd1);

        // Full path
        s0 = starts;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_drain(50);
        check("full_start_pulses", 64'(starts - s0), 64'd1);

        // FIFO full with a pending result
        res_ready = 1'b0;
        s0 = starts;
        push(32'h1000_0001, 32'h2000_0001, 64'h0200_0000_3000_0001);
        push(32'h2000_0002, 32'h2000_0002, 64'h0400_0000_8000_0004);
        push(32'h3000_0003, 32'h2000_0003, 64'h0600_0000_F000_0009);
        push(32'h4000_0004, 32'h2000_0004, 64'h0800_0001_8000_0010);
        push(32'h5000_0005, 32'h2000_0005, 64'h0A00_0002_3000_0019);
        in_valid = 1'b1;
        in_a     = 32'h6000_0006;
        in_b     = 32'h2000_0006;
        repeat (10) @(negedge clk);
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_res_valid", 64'(res_valid), 64'd1);
        check("full_no_issue", 64'(starts - s0), 64'd1);
        check("full_first_product", res_product, 64'h0200_0000_3000_0001);
        @(negedge clk);
        res_ready = 1'b1;
        push(32'h6000_0006, 32'h2000_0006, 64'h0C00_0003_0000_0024);
        wait_drain(200);
        check("full_total_issues", 64'(starts - s0), 64'd6);

        // Back-to-back drain and capture
        seen_rv = 0;
        max_gap = 0;
        s0      = starts;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        push(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        push(32'h8000_0000, 32'h0002_0000, 64'h0001_0000_0000_0000);
        push(32'h1234_5678, 32'h0001_0000, 64'h0000_1234_5678_0000);
        wait_drain(200);
        check("b2b_issues", 64'(starts - s0), 64'd4);
        check("b2b_max_gap", 64'(max_gap), 64'd5);

        // Reset in WAIT
        push(32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
        seen_start = 0;
        for (int i = 0; i < 50; i++) begin
            #4;
            if (mult_start) begin
                seen_start = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_saw_start", 64'(seen_start), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mult_start", 64'(mult_start), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        push(32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006);
        wait_drain(50);

`ifdef MULT_REQ_STATS_EN
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        meas      = 0;
        push(32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001);
        push(32'h0000_0007, 32'h0000_0009, 64'h0000_0000_0000_003F);
        push(32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000);
        wait_drain(100);
        #1;
        check("stats_op_count", 64'(op_count), 64'd3);
        check("stats_busy_vs_measured", 64'(busy_cycles), 64'(meas));
        check("stats_busy_cycles", 64'(busy_cycles), 64'd6);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check("stats_clr_op_count", 64'(op_count), 64'd0);
        check("stats_clr_busy_cycles", 64'(busy_cycles), 64'd0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult32x32_req_ctrl.md
Name: mult32x32_req_ctrl

Overview:
- Request front-end placed directly upstream of the mult32x32_fast multiplier (FSM plus datapath).
- Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Issues each pair to the multiplier with a one-cycle start pulse and waits for completion.
- Captures the 64-bit product into an output register drained on a valid/ready interface.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- mult_start  out  1  start pulse to the multiplier.
- mult_a  out  32  operand A to the multiplier; held stable while an operation is in flight.
- mult_b  out  32  operand B to the multiplier; held stable while an operation is in flight.
- mult_busy  in  1  multiplier busy.
- mult_product  in  64  multiplier product.
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accepts the result.
- res_product  out  64  registered product.

Behaviour:
- Reset state: state=IDLE, FIFO empty, rd/wr pointers and count 0, a_reg/b_reg 0, res_valid 0, res_product 0, mult_start 0. Consequently in_ready=1 out of reset.
- FIFO write: on in_valid && in_ready. Full means count==DEPTH. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count is unchanged; a push is allowed while full only if a pop occurs in the same cycle.
  - in_ready = !full || pop.
  - in_ready is combinational from pop.
- can_accept = !res_valid || res_ready.
- State IDLE:
  - If FIFO non-empty && can_accept && !mult_busy: pop the head into a_reg/b_reg, then go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - mult_start=1 for exactly this cycle; mult_a/mult_b = a_reg/b_reg.
  - Go to WAIT unconditionally.
  - mult_busy is ignored in this cycle, because the multiplier raises busy combinationally with start.
- State WAIT:
  - mult_start=0; operands stay held.
  - When mult_busy==0: load mult_product into res_product, set res_valid=1 on the next edge, and go to IDLE.
  - Both the fast path (an MSW of either operand is 0) and the 4-cycle full path are handled by this busy-falling check. No cycle count is assumed.
- Result handshake:
  - res_valid clears on res_valid && res_ready, unless a capture happens in the same cycle.
  - A capture in the same cycle as a drain leaves res_valid=1 with the new value.
  - Because an issue requires can_accept, a capture never overwrites an undrained result.
- Throughput: one operation in flight at a time. Back-to-back issue needs at least 3 cycles per op (IDLE, ISSUE, WAIT ≥1).
- Latency: from in_valid accepted on an empty FIFO in cycle t to res_valid=1 is t+1 (IDLE pop), t+2 (ISSUE), WAIT until mult_busy low, and res_valid on the following edge.
- mult_a/mult_b always equal a_reg/b_reg, so they are stable from ISSUE through WAIT.
- Reset mid-operation: all state returns to its reset value immediately. Queued operands and any pending result are discarded. The multiplier is reset by the same reset.
- res_ready while res_valid=0 has no effect. in_valid while full is ignored with no overwrite.

Optional Feature:
- Macro: MULT_REQ_STATS_EN.
- Defined:
  - Adds output op_count[31:0]: increments on every capture.
  - Adds output busy_cycles[31:0]: increments each cycle in ISSUE or WAIT.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
  - Adds input stats_clr: synchronous clear of both counters; takes priority over increment in the same cycle.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Fast path: in_a=0x00000003, in_b=0x00000005, res_ready=1 → one mult_start pulse; res_product=0x000000000000000F; res_valid high for exactly 1 cycle.
- Full path: in_a=in_b=0xFFFFFFFF → mult_a/mult_b stable across all busy cycles; res_product=0xFFFFFFFE00000001.
- FIFO full:
  - Stimulus: res_ready=0; push DEPTH+2 pairs (0x10000001*k, 0x20000000+k), k=1..6.
  - Required: in_ready drops once the FIFO holds DEPTH entries with one result pending; no further issue occurs while res_valid=1 and res_ready=0.
  - Then raise res_ready: all accepted products emerge in order with correct values; no pair is lost or duplicated.
- Simultaneous drain and capture: hold res_ready=1 continuously with a full FIFO → results are back-to-back with no drops, and res_valid never gaps longer than the issue cycles.
- Reset during WAIT of 0x12345678*0x9ABCDEF0 → res_valid=0, in_ready=1, FIFO empty; a following 2*3 yields 6.
- With MULT_REQ_STATS_EN: after 3 fast ops, op_count=3 and busy_cycles matches the measured ISSUE+WAIT cycles; stats_clr zeroes both counters.
